// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg : shared FSM/grant encodings for the memory port arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'b00,
      ARB_BUSY_I = 2'b01,
      ARB_BUSY_D = 2'b10,
      ARB_DONE   = 2'b11
   } arb_state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } gnt_id_t;

   // Word access type as encoded by the CPU control decoder (DMType).
   localparam logic [2:0] DM_WORD = 3'b000;

   function automatic logic [2:0] sat_inc3(input logic [2:0] v, input logic [2:0] lim);
      return (v >= lim) ? lim : v + 3'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_timer.sv
// ============================================================================
// mem_arb_timer : BUSY-cycle counter, flags expiry at TIMEOUT-1
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_arb_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam logic [7:0] C_LAST = 8'(TIMEOUT - 1);

   logic [7:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expired) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign o_expired = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one req/ack memory port between IF and MEM stages
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int TIMEOUT      = 255,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   output logic          if_err,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [2:0]    d_type,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ready,
   output logic          d_err,
   output logic          mem_req,
   output logic          mem_we,
   output logic [2:0]    mem_type,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack
);

   localparam logic [2:0] C_STARVE_LIM = 3'(STARVE_LIMIT);

   arb_state_t    r_state;
   arb_state_t    w_state_nxt;
   gnt_id_t       w_gnt_id;
   logic          w_grant;
   logic          w_fin_ok;
   logic          w_fin_to;
   logic          w_busy;
   logic          w_expired;

   logic [2:0]    r_starve;
   logic          r_mem_req;
   logic          r_mem_we;
   logic [2:0]    r_mem_type;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic [DW-1:0] r_if_rdata;
   logic [DW-1:0] r_d_rdata;
   logic          r_if_ready;
   logic          r_if_err;
   logic          r_d_ready;
   logic          r_d_err;

   assign w_busy = (r_state == ARB_BUSY_I) || (r_state == ARB_BUSY_D);

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_clr     (w_grant),
      .i_en      (w_busy),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Data normally wins; a fetch that has waited out STARVE_LIMIT data grants goes first.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_gnt_id    = GNT_IF;
      w_fin_ok    = 1'b0;
      w_fin_to    = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (d_req && !(if_req && (r_starve == C_STARVE_LIM))) begin
               w_grant     = 1'b1;
               w_gnt_id    = GNT_D;
               w_state_nxt = ARB_BUSY_D;
            end else if (if_req) begin
               w_grant     = 1'b1;
               w_gnt_id    = GNT_IF;
               w_state_nxt = ARB_BUSY_I;
            end
         end
         ARB_BUSY_I, ARB_BUSY_D: begin
            if (mem_ack) begin
               w_fin_ok    = 1'b1;
               w_state_nxt = ARB_DONE;
            end else if (w_expired) begin
               w_fin_to    = 1'b1;
               w_state_nxt = ARB_DONE;
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_starve    <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_type  <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_if_ready  <= 1'b0;
         r_if_err    <= 1'b0;
         r_d_ready   <= 1'b0;
         r_d_err     <= 1'b0;
      end else begin
         r_if_ready <= 1'b0;
         r_if_err   <= 1'b0;
         r_d_ready  <= 1'b0;
         r_d_err    <= 1'b0;
         if (w_grant) begin
            r_mem_req <= 1'b1;
            if (w_gnt_id == GNT_D) begin
               r_mem_we    <= d_we;
               r_mem_type  <= d_type;
               r_mem_addr  <= d_addr;
               r_mem_wdata <= d_wdata;
               r_starve    <= if_req ? sat_inc3(r_starve, C_STARVE_LIM) : 3'd0;
            end else begin
               r_mem_we    <= 1'b0;
               r_mem_type  <= DM_WORD;
               r_mem_addr  <= if_addr;
               r_mem_wdata <= '0;
               r_starve    <= 3'd0;
            end
         end
         // Ready pulses are raised on entry to DONE so they are high for the DONE cycle only.
         if (w_fin_ok || w_fin_to) begin
            r_mem_req <= 1'b0;
            if (r_state == ARB_BUSY_D) begin
               r_d_ready <= 1'b1;
               r_d_err   <= w_fin_to;
               r_d_rdata <= (w_fin_to || r_mem_we) ? '0 : mem_rdata;
            end else begin
               r_if_ready <= 1'b1;
               r_if_err   <= w_fin_to;
               r_if_rdata <= w_fin_to ? '0 : mem_rdata;
            end
         end
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_type  = r_mem_type;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign if_rdata  = r_if_rdata;
   assign if_ready  = r_if_ready;
   assign if_err    = r_if_err;
   assign d_rdata   = r_d_rdata;
   assign d_ready   = r_d_ready;
   assign d_err     = r_d_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        if_req, d_req, d_we, mem_ack;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [2:0]  d_type;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_ready, if_err, d_ready, d_err, mem_req, mem_we;
   logic [2:0]  mem_type;

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(255), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [2:0]  typ;
      logic [31:0] wdata;
   } gnt_t;

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } rsp_t;

   gnt_t gq[$];
   rsp_t rq[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   grant_cyc = 0;
   int   ack_delay = 1;
   bit   ack_en = 1'b1;
   bit   inject_ack = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0000_0013 : a + 32'h1000_0000;
   endfunction

   task automatic push_g(input logic [31:0] a, input logic we, input logic [2:0] t, input logic [31:0] wd);
      gnt_t g;
      g.addr = a; g.we = we; g.typ = t; g.wdata = wd;
      gq.push_back(g);
   endtask

   task automatic push_r(input logic is_d, input logic [31:0] rd, input logic err, input int lat);
      rsp_t r;
      r.is_d = is_d; r.rdata = rd; r.err = err; r.lat = lat;
      rq.push_back(r);
   endtask

   // Memory model: acks ack_delay cycles after mem_req rises (0 = same cycle).
   initial begin : mem_model
      int busy;
      busy = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #3;
         mem_ack = 1'b0;
         mem_rdata = '0;
         if (inject_ack) begin
            mem_ack = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
         end else if (mem_req) begin
            if (ack_en && busy == ack_delay) begin
               mem_ack = 1'b1;
               mem_rdata = rd_of(mem_addr);
            end
            busy++;
         end else begin
            busy = 0;
         end
      end
   end

   initial begin : mon_gnt
      logic prev;
      gnt_t g;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req && !prev) begin
            grant_cyc = cyc - 1;
            if (gq.size() == 0) begin
               n_chk++;
               $display("FAIL gnt_unexpected: got grant addr %h, expected none", mem_addr);
            end else begin
               g = gq.pop_front();
               chk("gnt_addr", mem_addr, g.addr);
               chk("gnt_we", {31'b0, mem_we}, {31'b0, g.we});
               chk("gnt_type", {29'b0, mem_type}, {29'b0, g.typ});
               if (g.we) chk("gnt_wdata", mem_wdata, g.wdata);
            end
         end
         prev = mem_req;
      end
   end

   initial begin : mon_rsp
      logic prev_rdy;
      rsp_t r;
      prev_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (if_ready || d_ready) begin
            chk("rdy_pulse_width", {31'b0, prev_rdy}, 32'd0);
            if (rq.size() == 0) begin
               n_chk++;
               $display("FAIL rdy_unexpected: got if_ready=%0b d_ready=%0b, expected none", if_ready, d_ready);
            end else begin
               r = rq.pop_front();
               chk("rdy_sel", {30'b0, if_ready, d_ready}, {30'b0, !r.is_d, r.is_d});
               chk(r.is_d ? "d_rdata" : "if_rdata", r.is_d ? d_rdata : if_rdata, r.rdata);
               chk(r.is_d ? "d_err" : "if_err", {31'b0, r.is_d ? d_err : if_err}, {31'b0, r.err});
               chk("latency", cyc - grant_cyc, r.lat);
            end
         end
         prev_rdy = if_ready || d_ready;
      end
   end

   task automatic wait_rdy(input bit is_d, output int rc);
      rc = -1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (is_d ? d_ready : if_ready) begin
            rc = cyc;
            break;
         end
      end
      if (rc < 0) begin
         n_chk++;
         $display("FAIL %s_ready_timeout: got no pulse in 600 cycles, expected one", is_d ? "d" : "if");
      end
   endtask

   task automatic if_txn(input logic [31:0] a, input bit last, output int rc);
      if_req = 1'b1;
      if_addr = a;
      wait_rdy(1'b0, rc);
      @(posedge clk); #2;
      if (last) if_req = 1'b0;
   endtask

   task automatic d_txn(input logic we, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] wd, input bit last);
      int rc;
      d_req = 1'b1; d_we = we; d_type = t; d_addr = a; d_wdata = wd;
      wait_rdy(1'b1, rc);
      @(posedge clk); #2;
      if (last) d_req = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int rc, rc2, hi;
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_type = 0; d_addr = 0; d_wdata = 0;
      reset_n = 1'b0;
      #1;
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_type", {29'b0, mem_type}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_rdy", {30'b0, if_ready, d_ready}, 32'd0);
      chk("rst_err", {30'b0, if_err, d_err}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk); #2;

      // Single IF read, ack two cycles after mem_req
      ack_delay = 2;
      push_g(32'h100, 1'b0, 3'b000, 32'h0);
      push_r(1'b0, 32'h0000_0013, 1'b0, 4);
      if_txn(32'h100, 1'b1, rc);
      repeat (2) @(posedge clk); #2;

      // Simultaneous requests: data store first, then fetch
      ack_delay = 1;
      push_g(32'h2000, 1'b1, 3'b000, 32'hCAFE_F00D);
      push_g(32'h200, 1'b0, 3'b000, 32'h0);
      push_r(1'b1, 32'h0, 1'b0, 3);
      push_r(1'b0, 32'h1000_0200, 1'b0, 3);
      fork
         if_txn(32'h200, 1'b1, rc);
         d_txn(1'b1, 3'b000, 32'h2000, 32'hCAFE_F00D, 1'b1);
      join
      repeat (2) @(posedge clk); #2;

      // Starvation: four data loads, then the pending fetch, then the fifth load
      for (int i = 0; i < 4; i++) push_g(32'h400 + 32'(4 * i), 1'b0, 3'b001, 32'h0);
      push_g(32'h300, 1'b0, 3'b000, 32'h0);
      push_g(32'h410, 1'b0, 3'b001, 32'h0);
      for (int i = 0; i < 4; i++) push_r(1'b1, 32'h1000_0400 + 32'(4 * i), 1'b0, 3);
      push_r(1'b0, 32'h1000_0300, 1'b0, 3);
      push_r(1'b1, 32'h1000_0410, 1'b0, 3);
      fork
         if_txn(32'h300, 1'b1, rc);
         begin
            for (int i = 0; i < 5; i++) d_txn(1'b0, 3'b001, 32'h400 + 32'(4 * i), 32'h0, i == 4);
         end
      join
      repeat (2) @(posedge clk); #2;

      // Starvation count was cleared: data wins contention again; store returns 0
      push_g(32'h2004, 1'b1, 3'b010, 32'h1234_5678);
      push_g(32'h304, 1'b0, 3'b000, 32'h0);
      push_r(1'b1, 32'h0, 1'b0, 3);
      push_r(1'b0, 32'h1000_0304, 1'b0, 3);
      fork
         if_txn(32'h304, 1'b1, rc);
         d_txn(1'b1, 3'b010, 32'h2004, 32'h1234_5678, 1'b1);
      join
      repeat (2) @(posedge clk); #2;

      // Timeout with no ack, then a late ack that must be ignored
      ack_en = 1'b0;
      push_g(32'h3000, 1'b0, 3'b000, 32'h0);
      push_r(1'b1, 32'h0, 1'b1, 256);
      d_req = 1'b1; d_we = 1'b0; d_type = 3'b000; d_addr = 32'h3000; d_wdata = 32'h0;
      hi = 0;
      rc = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (mem_req) hi++;
         if (d_ready) begin
            rc = cyc;
            break;
         end
      end
      if (rc < 0) begin
         n_chk++;
         $display("FAIL to_ready_timeout: got no d_ready in 400 cycles, expected one");
      end
      chk("to_req_cycles", hi, 255);
      @(posedge clk); #2 d_req = 1'b0;
      @(posedge clk); #2 inject_ack = 1'b1;
      @(posedge clk); #2 inject_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late_ack_idle", {31'b0, mem_req}, 32'd0);
      end
      ack_en = 1'b1;
      @(posedge clk); #2;

      // Asynchronous reset while a fetch is in BUSY_I
      ack_delay = 5;
      push_g(32'h500, 1'b0, 3'b000, 32'h0);
      if_req = 1'b1; if_addr = 32'h500;
      rc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req) begin
            rc = cyc;
            break;
         end
      end
      if (rc < 0) begin
         n_chk++;
         $display("FAIL rst_busy_timeout: got no mem_req in 20 cycles, expected one");
      end
      #1 reset_n = 1'b0;
      #1;
      chk("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("async_rst_rdy", {30'b0, if_ready, d_ready}, 32'd0);
      chk("async_rst_mem_addr", mem_addr, 32'd0);
      if_req = 1'b0;
      @(posedge clk); #2;
      @(posedge clk); #2 reset_n = 1'b1;
      ack_delay = 1;
      push_g(32'h504, 1'b0, 3'b000, 32'h0);
      push_r(1'b0, 32'h1000_0504, 1'b0, 3);
      @(posedge clk); #2;
      if_txn(32'h504, 1'b1, rc);
      repeat (2) @(posedge clk); #2;

      // Zero-wait ack, back-to-back fetches
      ack_delay = 0;
      push_g(32'h0, 1'b0, 3'b000, 32'h0);
      push_g(32'h4, 1'b0, 3'b000, 32'h0);
      push_r(1'b0, 32'h1000_0000, 1'b0, 2);
      push_r(1'b0, 32'h1000_0004, 1'b0, 2);
      if_txn(32'h0, 1'b0, rc);
      if_txn(32'h4, 1'b1, rc2);
      chk("zw_spacing", rc2 - rc, 3);

      repeat (3) @(posedge clk);
      chk("gnt_queue_empty", gq.size(), 0);
      chk("rsp_queue_empty", rq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
